// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 constants, state types and FIPS 180-4 round functions
package sha256_pkg;
  typedef logic [31:0] word_t;
  typedef logic [0:7][31:0] state_t;
  typedef enum logic [1:0] {BLK_A, BLK_B, BLK_2ND, BLK_IDLE} blk_e;
  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam state_t IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic word_t big_s0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic word_t big_s1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic word_t small_s0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic word_t small_s1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction
  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction
endpackage

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 compression round
//   s : working variables a..h in (index 0 = a)
//   w : schedule word W[t]
//   k : round constant K[t]
//   n : working variables a'..h' out
module sha256_round
  import sha256_pkg::*;
(
  input  state_t s,
  input  word_t  w,
  input  word_t  k,
  output state_t n
);
  word_t t1, t2;
  assign t1 = s[7] + big_s1(s[4]) + ch(s[4], s[5], s[6]) + k + w;
  assign t2 = big_s0(s[0]) + maj(s[0], s[1], s[2]);
  assign n = {t1 + t2, s[0], s[1], s[2], s[3] + t1, s[4], s[5], s[6]};
endmodule

// File: rtl/hash.sv
// hash: iterative double-SHA-256 engine, one round per clock, externally sequenced
//   clk     : clock
//   rst     : asynchronous active-high reset
//   block   : phase (0 header A, 1 header B, 2 second pass, 3 idle)
//   select  : step in phase (0..63 round, 64 feed-forward, >64 no-op)
//   msg_in  : W[select] for select<16 in blocks 0/1
//   h1..h8  : registered digest, h1 most significant
module hash
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  block,
  input  logic [6:0]  select,
  input  logic [31:0] msg_in,
  output logic [31:0] h1,
  output logic [31:0] h2,
  output logic [31:0] h3,
  output logic [31:0] h4,
  output logic [31:0] h5,
  output logic [31:0] h6,
  output logic [31:0] h7,
  output logic [31:0] h8
);
  state_t v, hs, dig, init, rin, rout, ff;
  logic [0:15][31:0] win;
  word_t w, w2;
  logic active;
  always_comb begin
    init = (block == BLK_B) ? hs : IV;
    rin = (select == 7'd0) ? init : v;
    // second-pass message: first-pass digest, then fixed padding for a 256-bit message
    w2 = (select < 7'd8) ? hs[select[2:0]] :
         (select == 7'd8) ? 32'h80000000 :
         (select == 7'd15) ? 32'h00000100 : 32'h0;
    // win[15] holds W[t-1], win[0] holds W[t-16]
    w = (select < 7'd16) ? ((block == BLK_2ND) ? w2 : msg_in) :
        small_s1(win[14]) + win[9] + small_s0(win[1]) + win[0];
    active = (block != BLK_IDLE) && (select <= 7'd64);
    for (int i = 0; i < 8; i++) ff[i] = init[i] + v[i];
  end
  sha256_round u_round (
    .s(rin),
    .w(w),
    .k(K[select[5:0]]),
    .n(rout)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v <= '0;
      hs <= '0;
      win <= '0;
      dig <= '0;
    end else if (active) begin
      if (select[6]) begin
        hs <= ff;
        if (block == BLK_2ND) dig <= ff;
      end else begin
        v <= rout;
        win <= {win[1:15], w};
      end
    end
  assign {h1, h2, h3, h4, h5, h6, h7, h8} = dig;
endmodule

// File: tb/tb_hash.sv
// tb_hash: directed double-SHA-256 checks of hash against constants and an independent model
module tb_hash;
  import sha256_pkg::K;
  import sha256_pkg::IV;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] blk;
  logic [6:0] sel;
  logic [31:0] msg;
  logic [31:0] h1, h2, h3, h4, h5, h6, h7, h8;
  logic [255:0] hv;
  int total = 0;
  int bad = 0;
  localparam logic [255:0] GEN_D =
    256'h6fe28c0a_b6f1b372_c1a6a246_ae63f74f_931e8365_e15a089c_68d61900_00000000;
  localparam logic [1023:0] GEN_H = {32'h01000000, 256'h0,
    256'h3ba3edfd_7a7b12b2_7ac72c3e_67768f61_7fc81bc3_888a5132_3a9fb8aa_4b1e5e4a,
    32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c, 32'h80000000, 320'h0, 32'h00000280};
  always #5 clk = ~clk;
  assign hv = {h1, h2, h3, h4, h5, h6, h7, h8};
  hash dut (
    .clk(clk), .rst(rst), .block(blk), .select(sel), .msg_in(msg),
    .h1(h1), .h2(h2), .h3(h3), .h4(h4), .h5(h5), .h6(h6), .h7(h7), .h8(h8)
  );
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction
  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] m);
    logic [31:0] w [64];
    logic [31:0] r [8];
    logic [31:0] t1, t2;
    logic [255:0] o;
    for (int i = 0; i < 8; i++) r[i] = hin[255-32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = m[511-32*t -: 32];
      else w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      t1 = r[7] + (ror(r[4], 6) ^ ror(r[4], 11) ^ ror(r[4], 25))
         + ((r[4] & r[5]) ^ (~r[4] & r[6])) + K[t] + w[t];
      t2 = (ror(r[0], 2) ^ ror(r[0], 13) ^ ror(r[0], 22)) + ((r[0] & r[1]) | (r[2] & (r[0] | r[1])));
      for (int i = 7; i > 0; i--) r[i] = r[i-1];
      r[4] = r[4] + t1;
      r[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) o[255-32*i -: 32] = hin[255-32*i -: 32] + r[i];
    return o;
  endfunction
  function automatic logic [255:0] dsha(input logic [1023:0] hdr);
    logic [255:0] ivw, a;
    ivw = IV;
    a = compress(ivw, hdr[1023:512]);
    a = compress(a, hdr[511:0]);
    return compress(ivw, {a, 32'h80000000, 192'h0, 32'h00000100});
  endfunction
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // step i of a job: block i/65, select i%65; step 195 is the idle cycle
  task automatic run(input logic [1023:0] hdr, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      blk = 2'(i / 65);
      sel = 7'(i % 65);
      msg = (i < 130 && i % 65 < 16) ? hdr[1023-32*((i/65)*16 + i%65) -: 32] : $urandom;
    end
  endtask
  initial begin
    logic [1023:0] n0, rh;
    rst = 1'b1;
    blk = 2'd3;
    sel = 7'd0;
    msg = 32'h0;
    #1 chk("reset", hv, 256'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run(GEN_H, 0, 195);
    chk("genesis", hv, GEN_D);
    @(negedge clk);
    chk("hold_idle", hv, GEN_D);
    n0 = GEN_H;
    n0[1023-32*19 -: 32] = 32'h0;
    run(n0, 0, 193);
    chk("hold_job2", hv, GEN_D);
    run(n0, 194, 195);
    chk("job2", hv, dsha(n0));
    run(GEN_H, 0, 100);
    @(negedge clk);
    blk = 2'd3;
    sel = 7'd0;
    msg = $urandom;
    @(negedge clk);
    blk = 2'd1;
    sel = 7'd100;
    @(negedge clk);
    blk = 2'd2;
    sel = 7'd127;
    @(negedge clk);
    blk = 2'd3;
    sel = 7'd0;
    chk("noop_hold", hv, dsha(n0));
    run(GEN_H, 101, 195);
    chk("noop_job", hv, GEN_D);
    run(GEN_H, 0, 95);
    #2 rst = 1'b1;
    #1 chk("async_rst", hv, 256'h0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_hold", hv, 256'h0);
    run(GEN_H, 0, 195);
    chk("post_rst", hv, GEN_D);
    for (int j = 0; j < 10; j++) begin
      for (int i = 0; i < 32; i++) rh[1023-32*i -: 32] = $urandom;
      run(rh, 0, 195);
      chk("rand", hv, dsha(rh));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hash.md
HASH -- requirements
Module: hash

Interface
REQ-001 Parameters: none; all widths fixed by SHA-256 (32-bit words, 64 rounds).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 block  input  2  phase of double-SHA-256 job: 0=header block A, 1=header block B, 2=second-pass hash, 3=idle.
REQ-005 select  input  7  step within a phase: 0..63 = round index, 64 = feed-forward step.
REQ-006 msg_in  input  32  message word W[select], valid at the rising edge while select<16 in block 0/1; ignored otherwise.
REQ-007 h1..h8  output  32 each  final double-SHA-256 digest words, h1 = most-significant word; registered.

Function
REQ-008 The sequencer (external) SHALL present: block 0, select 0..64; block 1, select 0..64; block 2, select 0..64; block 3, select 0 (one cycle); repeat. This gives 196 cycles per job.
REQ-009 W schedule: for select 0..15, W[select]=msg_in (block 0/1). For select 16..63, W[t]=s1(W[t-2])+W[t-7]+s0(W[t-15])+W[t-16] mod 2^32, using a 16-word sliding window.
REQ-010 Block 2 message SHALL be generated internally, not taken from msg_in: W0..W7 = chaining state after block 1, W8=0x80000000, W9..W14=0, W15=0x00000100.
REQ-011 Round t (select=t, 0..63): working variables a..h SHALL be updated by the standard SHA-256 compression round with K[t]. At select 0 the round input is the initial state, not the old a..h.
REQ-012 Initial state: block 0 and block 2 use the SHA-256 IV (0x6a09e667 .. 0x5be0cd19); block 1 uses chaining state H produced by block 0.
REQ-013 select 64: H SHALL become initial state + a..h (per word, mod 2^32).
REQ-014 At select 64 of block 2, h1..h8 SHALL load the block-2 feed-forward result in the same edge.
REQ-015 h1..h8 SHALL hold that value through block 3 and the whole next job until the next block-2 select-64 edge.
REQ-016 Block 3 and any select value >64 SHALL be no-ops: no state changes.
REQ-017 All arithmetic SHALL be modulo 2^32.
REQ-018 Rotation/shift functions follow FIPS 180-4: S0, S1, s0, s1, Ch, Maj.
REQ-019 Latency: the digest is visible at h1..h8 one cycle after the block-2 select-64 edge. That is 195 cycles after the first block-0 select-0 edge.
REQ-020 Jobs SHALL run back-to-back without gaps. No handshake; the sequencer is trusted.

Reset
REQ-021 rst high SHALL asynchronously clear a..h, H, the W window and h1..h8 to 0.
REQ-022 rst asserted mid-job SHALL abandon that job; h1..h8 read 0 until a complete job finishes after release.
REQ-023 After rst deasserts, the first valid job begins at the next block-0 select-0 edge.

Structure
REQ-024 Shared package sha256_pkg SHALL hold:
- the K[0..63] constant table
- the 8 IV words
- the S0/S1/s0/s1/Ch/Maj functions
REQ-025 One sub-module, sha256_round (combinational single round: a..h, W, K -> a'..h'), SHALL be instantiated once.
REQ-026 The block SHALL be single-round iterative: one round per clock and no unrolling. The implementation target is 120-400 lines.

Verification
REQ-027 Bitcoin genesis header (80 bytes padded to 32 words), fed in block 0/1 -> after block 2, h1..h8 = 6fe28c0a b6f1b372 c1a6a246 ae63f74f 931e8365 e15a089c 68d61900 00000000.
REQ-028 Two consecutive jobs, genesis header then nonce word (word 19) changed to 0 -> h1..h8 hold the genesis digest until the second job's block-2 select-64 edge, then change to the reference-model value.
REQ-029 rst pulsed during block 1 select 30 -> h1..h8 = 0 immediately (asynchronous); next full job yields the correct digest.
REQ-030 msg_in driven with random junk for select 16..64 and during all of block 2/3 -> digest unchanged vs REQ-027.
REQ-031 Block 3 held for one cycle with select 0 -> no internal register changes (check a..h, H, h1..h8 stable).
REQ-032 Random 32-word headers, 1000 jobs -> h1..h8 match a software double-SHA-256 model (second-pass words in natural word order).
